// File: rtl/viterbi_chk_pkg.sv
// Shared types and default sizing for the Viterbi BER checker.
package viterbi_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  localparam int MAX_LAT_DEF  = 64;
  localparam int LOCK_RUN_DEF = 16;
  localparam int WIN_LEN_DEF  = 32;
  localparam int LOSS_THR_DEF = 8;
  localparam int CNT_W        = 32;

endpackage

// File: rtl/bit_history.sv
// Delay line of {valid, bit} samples; entry k holds the sample taken k+1
// cycles ago. Only the valid flags are reset, so stale data never compares.
module bit_history #(
  parameter  int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_i,
  input  logic             bit_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_vld_o,
  output logic             rd_bit_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] bit_q;

  // valid flags shift every cycle and are cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], vld_i};
    end
  end

  // data bits shift every cycle without reset
  always_ff @(posedge clk) begin
    bit_q <= {bit_q[DEPTH-2:0], bit_i};
  end

  assign rd_vld_o = vld_q[rd_idx_i];
  assign rd_bit_o = bit_q[rd_idx_i];

endmodule

// File: rtl/viterbi_ber_checker.sv
// Finds the decoder latency by searching the tx history for a run of
// matching bits, then counts compares and bit errors while locked.
// Lock is dropped when one window collects too many errors.
module viterbi_ber_checker
  import viterbi_chk_pkg::*;
#(
  parameter  int MAX_LAT  = MAX_LAT_DEF,
  parameter  int LOCK_RUN = LOCK_RUN_DEF,
  parameter  int WIN_LEN  = WIN_LEN_DEF,
  parameter  int LOSS_THR = LOSS_THR_DEF,
  localparam int LAT_W    = $clog2(MAX_LAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_bit_i,
  input  logic             tx_valid_i,
  input  logic             rx_bit_i,
  input  logic             rx_valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic [LAT_W-1:0] latency_o,
  output logic [CNT_W-1:0] bit_ct_o,
  output logic [CNT_W-1:0] err_ct_o
);

  localparam int RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int WCMP_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int WERR_W = $clog2(WIN_LEN + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  chk_state_e        state_q;
  logic [LAT_W-1:0]  lat_q;
  logic [LAT_W-1:0]  lat_d;
  logic [RUN_W-1:0]  run_q;
  logic [WCMP_W-1:0] wcmp_q;
  logic [WERR_W-1:0] werr_q;
  logic [WERR_W-1:0] werr_d;
  logic [CNT_W-1:0]  bct_q;
  logic [CNT_W-1:0]  bct_d;
  logic [CNT_W-1:0]  ect_q;
  logic [CNT_W-1:0]  ect_d;
  logic              locked_q;

  logic hist_vld;
  logic hist_bit;
  logic cmp;
  logic miss;
  logic run_hit;
  logic win_last;
  logic win_lost;

  bit_history #(
    .DEPTH(MAX_LAT)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst),
    .vld_i   (tx_valid_i),
    .bit_i   (tx_bit_i),
    .rd_idx_i(lat_q),
    .rd_vld_o(hist_vld),
    .rd_bit_o(hist_bit)
  );

  // compare qualification and next values of the counters
  assign cmp      = rx_valid_i && hist_vld;
  assign miss     = cmp && (rx_bit_i != hist_bit);
  assign lat_d    = (int'(lat_q) == MAX_LAT - 1) ? '0 : lat_q + 1'b1;
  assign run_hit  = (int'(run_q) + 1 >= LOCK_RUN);
  assign win_last = (int'(wcmp_q) == WIN_LEN - 1);
  // the window-closing compare contributes to its own window total
  assign werr_d   = werr_q + WERR_W'(miss);
  assign win_lost = (int'(werr_d) >= LOSS_THR);
  assign bct_d    = sat_inc(bct_q);
  assign ect_d    = sat_inc(ect_q);

  // lock FSM with counters; clear has priority over any compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      lat_q    <= '0;
      run_q    <= '0;
      wcmp_q   <= '0;
      werr_q   <= '0;
      bct_q    <= '0;
      ect_q    <= '0;
      locked_q <= 1'b0;
    end else if (clear_i) begin
      state_q  <= ST_IDLE;
      lat_q    <= '0;
      run_q    <= '0;
      wcmp_q   <= '0;
      werr_q   <= '0;
      bct_q    <= '0;
      ect_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid_i) begin
            state_q <= ST_SEARCH;
            lat_q   <= '0;
            run_q   <= '0;
          end
        end
        ST_SEARCH: begin
          if (cmp) begin
            if (miss) begin
              run_q <= '0;
              lat_q <= lat_d;
            end else if (run_hit) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
              run_q    <= '0;
              wcmp_q   <= '0;
              werr_q   <= '0;
            end else begin
              run_q <= run_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (cmp) begin
            bct_q <= bct_d;
            if (miss) begin
              ect_q <= ect_d;
            end
            if (win_last) begin
              wcmp_q <= '0;
              werr_q <= '0;
              if (win_lost) begin
                state_q  <= ST_SEARCH;
                locked_q <= 1'b0;
                run_q    <= '0;
              end
            end else begin
              wcmp_q <= wcmp_q + 1'b1;
              werr_q <= werr_d;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked_o  = locked_q;
  assign latency_o = lat_q;
  assign bit_ct_o  = bct_q;
  assign err_ct_o  = ect_q;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Scoreboard bench for viterbi_ber_checker: a driver streams PRBS7 tx bits
// and a delayed (optionally corrupted) rx copy; the control thread queues
// expected outputs per cycle and a monitor compares them on the falling edge.
// A delay of d means rx equals the tx bit that entered the history d+1
// cycles earlier, i.e. the bit held in history entry d.
module tb_viterbi_ber_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_bit_i = 1'b0;
  logic        tx_valid_i = 1'b0;
  logic        rx_bit_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        locked_o;
  logic [5:0]  latency_o;
  logic [31:0] bit_ct_o;
  logic [31:0] err_ct_o;

  viterbi_ber_checker #(
    .MAX_LAT (64),
    .LOCK_RUN(16),
    .WIN_LEN (32),
    .LOSS_THR(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_bit_i  (tx_bit_i),
    .tx_valid_i(tx_valid_i),
    .rx_bit_i  (rx_bit_i),
    .rx_valid_i(rx_valid_i),
    .clear_i   (clear_i),
    .locked_o  (locked_o),
    .latency_o (latency_o),
    .bit_ct_o  (bit_ct_o),
    .err_ct_o  (err_ct_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int    due;
    string name;
    logic  lk;
    int    lat;
    bit    chk_lat;
    int    bct;
    int    ect;
  } exp_t;

  exp_t sbq[$];

  task automatic expect_at(input int due, input string nm, input logic lk,
                           input int lat, input bit chk_lat, input int bct, input int ect);
    exp_t e;
    int i;
    e.due = due; e.name = nm; e.lk = lk; e.lat = lat;
    e.chk_lat = chk_lat; e.bct = bct; e.ect = ect;
    i = 0;
    while (i < sbq.size() && sbq[i].due <= due) i++;
    sbq.insert(i, e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        if (e.due < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s due at cycle %0d, reached only at %0d", e.name, e.due, cyc);
        end else begin
          chk({e.name, ".locked"}, 32'(locked_o), 32'(e.lk));
          if (e.chk_lat) chk({e.name, ".latency"}, 32'(latency_o), e.lat);
          chk({e.name, ".bit_ct"}, bit_ct_o, e.bct);
          chk({e.name, ".err_ct"}, err_ct_o, e.ect);
        end
      end
    end
  end

  // ---------------- stimulus driver ----------------
  int   dly = 5;
  bit   rx_en = 1'b0;
  int   fmode = 0;      // 0 clean, 1 flip every 8th edge from fbase, 2 flip edges fbase+bs..fbase+be
  int   fbase = 0;
  int   bs = 0;
  int   be = -1;
  bit   txh [16384];
  logic [6:0] lfsr = 7'h01;
  bit   nb;
  bit   rb;
  int   src;
  int   edge_n;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      edge_n = cyc + 1;
      nb = lfsr[6] ^ lfsr[5];
      lfsr = {lfsr[5:0], nb};
      tx_bit_i = nb;
      tx_valid_i = 1'b1;
      txh[edge_n % 16384] = nb;
      src = cyc - dly;
      rb = (src >= 0) ? txh[src % 16384] : 1'b0;
      if (fmode == 1 && ((edge_n - fbase) % 8 == 0)) rb = ~rb;
      if (fmode == 2 && (edge_n - fbase) >= bs && (edge_n - fbase) <= be) rb = ~rb;
      rx_valid_i = rx_en;
      rx_bit_i = rx_en ? rb : 1'b0;
    end
  end

  // ---------------- control ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_lock(input string nm, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (locked_o === 1'b1) begin
        at = cyc;
        break;
      end
    end
    checks++;
    if (at < 0) begin
      errors++;
      $display("FAIL %s locked_o got 0 after %0d cycles, expected 1", nm, budget);
      at = cyc;
    end
  endtask

  initial begin
    int n0, n1, n2, n3;
    bit seen_lock, seen63, wrapped;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.locked", 32'(locked_o), 0);
    chk("reset.latency", 32'(latency_o), 0);
    expect_at(cyc + 1, "reset_hold", 1'b0, 0, 1'b1, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    expect_at(cyc + 1, "idle_after_release", 1'b0, 0, 1'b1, 0, 0);
    @(negedge clk);

    // clean stream at delay 5
    dly = 5;
    rx_en = 1'b1;
    wait_lock("lock_d5", 400, n0);
    chk("lock_d5.latency", 32'(latency_o), 5);
    chk("lock_d5.bit_ct", bit_ct_o, 0);
    expect_at(n0 + 1, "d5_first", 1'b1, 5, 1'b1, 1, 0);

    // one flip every 8 compares: 4 errors per window, lock held
    fbase = n0;
    fmode = 1;
    expect_at(n0 + 32, "ber8_win1", 1'b1, 5, 1'b1, 32, 4);
    expect_at(n0 + 64, "ber8_64", 1'b1, 5, 1'b1, 64, 8);
    expect_at(n0 + 128, "ber8_128", 1'b1, 5, 1'b1, 128, 16);
    wait_until(n0 + 128);
    fmode = 0;

    // burst of 8 flips inside window 6 (edges n0+161..n0+192)
    bs = 170;
    be = 177;
    fmode = 2;
    expect_at(n0 + 160, "burst_pre", 1'b1, 5, 1'b1, 160, 16);
    expect_at(n0 + 191, "burst_last_locked", 1'b1, 5, 1'b1, 191, 24);
    expect_at(n0 + 192, "burst_drop", 1'b0, 5, 1'b1, 192, 24);
    expect_at(n0 + 200, "burst_search_hold", 1'b0, 5, 1'b1, 192, 24);
    expect_at(n0 + 207, "burst_prerelock", 1'b0, 5, 1'b1, 192, 24);
    expect_at(n0 + 208, "burst_relock", 1'b1, 5, 1'b1, 192, 24);
    expect_at(n0 + 209, "burst_count_resume", 1'b1, 5, 1'b1, 193, 24);

    // clear together with a valid compare
    wait_until(n0 + 220);
    fmode = 0;
    expect_at(n0 + 221, "clear_cycle", 1'b0, 0, 1'b1, 0, 0);
    expect_at(n0 + 222, "clear_next", 1'b0, 0, 1'b1, 0, 0);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    wait_lock("relock_clear", 400, n1);
    chk("relock_clear.latency", 32'(latency_o), 5);
    expect_at(n1 + 10, "relock_clear_cnt", 1'b1, 5, 1'b1, 10, 0);

    // asynchronous reset while locked
    wait_until(n1 + 20);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst.locked", 32'(locked_o), 0);
    chk("async_rst.latency", 32'(latency_o), 0);
    chk("async_rst.bit_ct", bit_ct_o, 0);
    chk("async_rst.err_ct", err_ct_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_lock("relock_rst", 400, n2);
    chk("relock_rst.latency", 32'(latency_o), 5);
    expect_at(n2 + 4, "relock_rst_cnt", 1'b1, 5, 1'b1, 4, 0);
    wait_until(n2 + 6);

    // delay 63: deepest history entry
    clear_i = 1'b1;
    dly = 63;
    @(negedge clk);
    clear_i = 1'b0;
    wait_lock("lock_d63", 1500, n3);
    chk("lock_d63.latency", 32'(latency_o), 63);
    expect_at(n3 + 3, "d63_cnt", 1'b1, 63, 1'b1, 3, 0);
    wait_until(n3 + 5);

    // delay 64: beyond the history, latency must wrap and never lock
    clear_i = 1'b1;
    dly = 64;
    @(negedge clk);
    clear_i = 1'b0;
    expect_at(cyc + 500, "d64_500", 1'b0, 0, 1'b0, 0, 0);
    expect_at(cyc + 1500, "d64_1500", 1'b0, 0, 1'b0, 0, 0);
    seen_lock = 1'b0;
    seen63 = 1'b0;
    wrapped = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (locked_o === 1'b1) seen_lock = 1'b1;
      if (latency_o == 6'd63) seen63 = 1'b1;
      if (seen63 && latency_o == 6'd0) wrapped = 1'b1;
    end
    chk("d64_never_locked", 32'(seen_lock), 0);
    chk("d64_latency_wrap", 32'(wrapped), 1);

    for (int k = 0; k < 10 && sbq.size() != 0; k++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
